mem_stage: RTL and testbench

- Memory stage of the 5-stage ARM pipeline, directly downstream of the EXE/EXE-register pair.
- Consumes ALU_res (as address), val_rm (as store data), dest and the MEM_R/MEM_W/WB_EN controls.
- Holds the word-addressed data memory, models a fixed multi-cycle access latency, and asserts freeze to stall all upstream stages.
- Contains its own MEM/WB output register feeding the write-back stage.

---
 rtl/mem_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_stage.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage ARM pipeline.
// - Word-addressed data memory with a fixed multi-cycle access latency.
// - freeze stalls the upstream stages while an access is in progress.
// - Includes the MEM/WB output register.
module mem_stage #(
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN,
  input  logic        MEM_R,
  input  logic        MEM_W,
  input  logic [31:0] ALU_res,
  input  logic [31:0] val_rm,
  input  logic [3:0]  dest,
  output logic        freeze,
  output logic        WB_EN_out,
  output logic        MEM_R_out,
  output logic [31:0] ALU_res_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  dest_out,
  output logic        addr_err
);

  // Counter width is at least 1 so that a zero-latency build stays legal.
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] BASE = 32'(BASE_ADDR);
  localparam logic [31:0] DEP  = 32'(DEPTH);
  localparam logic [CW-1:0] WC = CW'(WAIT_CYCLES);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          wb_en_q, wb_en_d;
  logic          mem_r_q, mem_r_d;
  logic [31:0]   alu_q, alu_d;
  logic [31:0]   mdata_q, mdata_d;
  logic [3:0]    dest_q, dest_d;
  logic          aerr_q, aerr_d;

  logic [31:0]   mem_q [DEPTH];

  logic          req, access, bubble, in_range, mem_we;
  logic [31:0]   off, idx, rdata;
  logic [AW-1:0] idx_w;

  // Address decode: byte offset from BASE, low two bits dropped.
  always_comb begin
    req      = MEM_R | MEM_W;
    off      = ALU_res - BASE;
    idx      = off >> 2;
    in_range = (ALU_res >= BASE) && (idx < DEP);
    idx_w    = idx[AW-1:0];
    rdata    = mem_q[idx_w];
  end

  // Next-state logic; freeze is forced low while reset is held so upstream
  // is released the moment reset asserts, even with a request still present.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    freeze  = 1'b0;
    access  = 1'b0;
    bubble  = 1'b0;
    if (rst) begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (WAIT_CYCLES == 0) begin
              access = 1'b1;
            end else begin
              freeze  = 1'b1;
              bubble  = 1'b1;
              state_d = S_WAIT;
              cnt_d   = CW'(1);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == WC) begin
            access  = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            freeze = 1'b1;
            bubble = 1'b1;
            cnt_d  = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // MEM/WB register next values: pass-through, bubble, or access result.
  always_comb begin
    wb_en_d = wb_en_q;
    mem_r_d = mem_r_q;
    alu_d   = alu_q;
    mdata_d = mdata_q;
    dest_d  = dest_q;
    aerr_d  = 1'b0;
    mem_we  = 1'b0;
    if (access) begin
      wb_en_d = WB_EN;
      mem_r_d = MEM_R;
      alu_d   = ALU_res;
      dest_d  = dest;
      aerr_d  = ~in_range;
      // A simultaneous read+write is executed as a store with zero load data.
      mem_we  = MEM_W & in_range;
      if (MEM_W && MEM_R)
        mdata_d = '0;
      else if (MEM_R)
        mdata_d = in_range ? rdata : '0;
    end else if (bubble) begin
      wb_en_d = 1'b0;
      mem_r_d = 1'b0;
    end else if (!req) begin
      wb_en_d = WB_EN;
      mem_r_d = MEM_R;
      alu_d   = ALU_res;
      dest_d  = dest;
    end
  end

  // FSM and output register, async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wb_en_q <= 1'b0;
      mem_r_q <= 1'b0;
      alu_q   <= '0;
      mdata_q <= '0;
      dest_q  <= '0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_en_q <= wb_en_d;
      mem_r_q <= mem_r_d;
      alu_q   <= alu_d;
      mdata_q <= mdata_d;
      dest_q  <= dest_d;
      aerr_q  <= aerr_d;
    end
  end

  // Data memory: contents survive reset; writes only on the access edge.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_w] <= val_rm;
  end

  assign WB_EN_out    = wb_en_q;
  assign MEM_R_out    = mem_r_q;
  assign ALU_res_out  = alu_q;
  assign mem_data_out = mdata_q;
  assign dest_out     = dest_q;
  assign addr_err     = aerr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a WAIT_CYCLES=3 and a WAIT_CYCLES=0 instance share
// stimulus; sel picks which one is checked for the current operation.
module tb_mem_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        wb_en = 0, mem_r = 0, mem_w = 0;
  logic [31:0] alu = '0, rm = '0;
  logic [3:0]  dst = '0;
  bit          sel = 0;

  logic        f3, wbo3, mro3, ae3, f0, wbo0, mro0, ae0;
  logic [31:0] alo3, mdo3, alo0, mdo0;
  logic [3:0]  dso3, dso0;

  mem_stage #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .WB_EN(wb_en), .MEM_R(mem_r), .MEM_W(mem_w),
    .ALU_res(alu), .val_rm(rm), .dest(dst), .freeze(f3), .WB_EN_out(wbo3),
    .MEM_R_out(mro3), .ALU_res_out(alo3), .mem_data_out(mdo3),
    .dest_out(dso3), .addr_err(ae3));

  mem_stage #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .WB_EN(wb_en), .MEM_R(mem_r), .MEM_W(mem_w),
    .ALU_res(alu), .val_rm(rm), .dest(dst), .freeze(f0), .WB_EN_out(wbo0),
    .MEM_R_out(mro0), .ALU_res_out(alo0), .mem_data_out(mdo0),
    .dest_out(dso0), .addr_err(ae0));

  wire        frz = sel ? f0   : f3;
  wire        wbo = sel ? wbo0 : wbo3;
  wire        mro = sel ? mro0 : mro3;
  wire        ae  = sel ? ae0  : ae3;
  wire [31:0] alo = sel ? alo0 : alo3;
  wire [31:0] mdo = sel ? mdo0 : mdo3;
  wire [3:0]  dso = sel ? dso0 : dso3;

  typedef struct {
    bit          w0;
    logic        wb, r, w;
    logic [31:0] addr, data;
    logic [3:0]  dest;
    int          fz;
    logic        err;
    bit          dc;
    logic [31:0] xd;
  } vec_t;

  vec_t tab[$];
  vec_t sb[$];
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit w0, logic wb, logic r, logic w, logic [31:0] addr,
                              logic [31:0] data, logic [3:0] d, int fz, logic err,
                              bit dc, logic [31:0] xd);
    vec_t v;
    v.w0 = w0; v.wb = wb; v.r = r; v.w = w; v.addr = addr; v.data = data;
    v.dest = d; v.fz = fz; v.err = err; v.dc = dc; v.xd = xd;
    return v;
  endfunction

  // Drive one op at a negedge, count freeze cycles, check the access result.
  task automatic run(input vec_t v);
    vec_t e;
    int   fc;
    sel = v.w0; wb_en = v.wb; mem_r = v.r; mem_w = v.w;
    alu = v.addr; rm = v.data; dst = v.dest;
    sb.push_back(v);
    fc = 0;
    #1;
    while (frz && fc < 20) begin
      fc++;
      @(posedge clk); #1;
      chk("bubble_wb", 32'(wbo), 32'd0);
      chk("bubble_err", 32'(ae), 32'd0);
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("freeze_cycles", 32'(fc), 32'(e.fz));
    chk("wb_en_out", 32'(wbo), 32'(e.wb));
    chk("mem_r_out", 32'(mro), 32'(e.r));
    chk("alu_res_out", alo, e.addr);
    chk("dest_out", 32'(dso), 32'(e.dest));
    chk("addr_err", 32'(ae), 32'(e.err));
    if (!e.dc) chk("mem_data_out", mdo, e.xd);
    @(negedge clk);
  endtask

  task automatic idle();
    wb_en = 0; mem_r = 0; mem_w = 0; alu = '0; rm = '0; dst = '0;
  endtask

  initial begin
    //               w0 wb r  w  addr   data          d  fz err dc xd
    tab.push_back(mk(0, 1, 0, 0, 32'h12, 32'h0,        3, 0, 0, 1, 32'h0));
    tab.push_back(mk(0, 0, 0, 1, 1028,   32'hDEADBEEF, 0, 3, 0, 1, 32'h0));
    tab.push_back(mk(0, 1, 1, 0, 1028,   32'h0,        5, 3, 0, 0, 32'hDEADBEEF));
    tab.push_back(mk(0, 1, 1, 0, 1031,   32'h0,        6, 3, 0, 0, 32'hDEADBEEF));
    tab.push_back(mk(0, 1, 1, 0, 1000,   32'h0,        7, 3, 1, 0, 32'h0));
    tab.push_back(mk(0, 1, 1, 0, 1280,   32'h0,        8, 3, 1, 0, 32'h0));
    tab.push_back(mk(0, 0, 0, 1, 1044,   32'h55AA55AA, 0, 3, 0, 1, 32'h0));
    tab.push_back(mk(0, 1, 0, 1, 1300,   32'hBAD0BAD0, 9, 3, 1, 1, 32'h0));
    tab.push_back(mk(0, 1, 1, 0, 1044,   32'h0,        2, 3, 0, 0, 32'h55AA55AA));
    tab.push_back(mk(0, 1, 1, 0, 1028,   32'h0,        2, 3, 0, 0, 32'hDEADBEEF));
    tab.push_back(mk(0, 0, 0, 1, 1276,   32'hCAFEF00D, 0, 3, 0, 1, 32'h0));
    tab.push_back(mk(0, 1, 1, 0, 1276,   32'h0,        4, 3, 0, 0, 32'hCAFEF00D));
    tab.push_back(mk(0, 1, 1, 1, 1032,   32'h0BADCAFE, 1, 3, 0, 0, 32'h0));
    tab.push_back(mk(0, 1, 1, 0, 1032,   32'h0,        1, 3, 0, 0, 32'h0BADCAFE));
    tab.push_back(mk(0, 0, 0, 1, 1028,   32'h12345678, 0, 3, 0, 1, 32'h0));
    tab.push_back(mk(0, 1, 1, 0, 1028,   32'h0,       10, 3, 0, 0, 32'h12345678));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_freeze3", 32'(f3), 32'd0);
    chk("rst_wb3", 32'(wbo3), 32'd0);
    chk("rst_alu3", alo3, 32'd0);
    chk("rst_mdata3", mdo3, 32'd0);
    chk("rst_dest0", 32'(dso0), 32'd0);
    chk("rst_err0", 32'(ae0), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tab[i]) run(tab[i]);

    // Reset in the second wait cycle of a store: the store must not land.
    sel = 0; wb_en = 0; mem_r = 0; mem_w = 1; alu = 1032; rm = 32'hFFFFFFFF; dst = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_abort_freeze", 32'(f3), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_freeze", 32'(f3), 32'd0);
    chk("abort_wb", 32'(wbo3), 32'd0);
    chk("abort_mem_r", 32'(mro3), 32'd0);
    chk("abort_alu", alo3, 32'd0);
    chk("abort_mdata", mdo3, 32'd0);
    chk("abort_dest", 32'(dso3), 32'd0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    run(mk(0, 1, 1, 0, 1032, 32'h0, 11, 3, 0, 0, 32'h0BADCAFE));
    run(mk(0, 1, 1, 0, 1028, 32'h0, 12, 3, 0, 0, 32'h12345678));

    // Zero-latency instance: store then immediate load, never freezes.
    run(mk(1, 0, 0, 1, 1024, 32'hA5A50001, 0, 0, 0, 1, 32'h0));
    run(mk(1, 1, 1, 0, 1024, 32'h0,        7, 0, 0, 0, 32'hA5A50001));
    run(mk(1, 0, 0, 1, 1024, 32'h0000BEEF, 0, 0, 0, 1, 32'h0));
    run(mk(1, 1, 1, 0, 1027, 32'h0,        8, 0, 0, 0, 32'h0000BEEF));
    run(mk(1, 1, 1, 0, 1000, 32'h0,        9, 0, 1, 0, 32'h0));
    run(mk(1, 1, 0, 0, 32'h77, 32'h0,     13, 0, 0, 1, 32'h0));
    chk("w0_err_pulse_end", 32'(ae0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
